// File: rtl/acq_pkg.sv
// acq_pkg: shared types, defaults and helpers for the acquisition frame sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package acq_pkg;

  // Sequencer states: idle, armed waiting for slot 0, streaming frames
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } acq_state_e;

  // 32 channels plus 3 aux slots per frame
  localparam int SLOTS_PER_FRAME_DEFAULT = 35;

  // Counters up to this width go through the shared saturating helper
  localparam int SAT_W = 64;

  // Increment that sticks at max_val instead of wrapping
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] val,
                                               input logic [SAT_W-1:0] max_val);
    return (val >= max_val) ? val : val + SAT_W'(1);
  endfunction

endpackage

// File: rtl/acq_frame_sequencer_slot_counter.sv
// acq_slot_counter: free-running slot index advanced by the chip sequencer tick.
// Latency: slot updates one clk after each tick; is_first/is_last decode the current slot.
// Backpressure: none; the counter follows tick regardless of sequencer state.
module acq_slot_counter
  import acq_pkg::*;
#(
  parameter int SLOTS  = SLOTS_PER_FRAME_DEFAULT,
  parameter int SLOT_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  output logic [SLOT_W-1:0] slot,
  output logic              is_first,
  output logic              is_last
);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);

  logic [SLOT_W-1:0] slot_q, slot_d;

  // Advance on tick, wrapping from the last slot back to 0
  always_comb begin
    slot_d = slot_q;
    if (tick) begin
      slot_d = (slot_q == LAST_SLOT) ? '0 : slot_q + SLOT_W'(1);
    end
  end

  // Slot register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot     = slot_q;
  assign is_first = (slot_q == '0);
  assign is_last  = (slot_q == LAST_SLOT);

endmodule

// File: rtl/acq_frame_sequencer.sv
// acq_frame_sequencer: turns the synchronized enable level into frame-aligned sample strobes.
// Latency: strobes, pulses and counters update one clk after the qualifying tick.
// Backpressure: fifo_full at a slot-0 tick skips that whole frame and counts a drop.
// Optional macro ACQ_FRAME_LIMIT_EN adds frame_limit/limit_done to stop after N frames.
module acq_frame_sequencer
  import acq_pkg::*;
#(
  parameter int SLOTS_PER_FRAME = SLOTS_PER_FRAME_DEFAULT,
  parameter int SLOT_W          = 6,
  parameter int CNT_W           = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              tick,
  input  logic              fifo_full,
`ifdef ACQ_FRAME_LIMIT_EN
  input  logic [CNT_W-1:0]  frame_limit,
  output logic              limit_done,
`endif
  output logic              running,
  output logic              sample_valid,
  output logic [SLOT_W-1:0] slot_idx,
  output logic              frame_start,
  output logic              frame_end,
  output logic [CNT_W-1:0]  frame_count,
  output logic [CNT_W-1:0]  drop_count
);

  localparam logic [SAT_W-1:0] CNT_MAX = SAT_W'({CNT_W{1'b1}});

  logic [SLOT_W-1:0] cur_slot;
  logic              slot_first, slot_last;

  acq_slot_counter #(
    .SLOTS  (SLOTS_PER_FRAME),
    .SLOT_W (SLOT_W)
  ) u_slot_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .slot     (cur_slot),
    .is_first (slot_first),
    .is_last  (slot_last)
  );

  acq_state_e        state_q, state_d;
  logic              accepted_q, accepted_d;
  logic              running_q, running_d;
  logic              sample_valid_q, sample_valid_d;
  logic [SLOT_W-1:0] slot_idx_q, slot_idx_d;
  logic              frame_start_q, frame_start_d;
  logic              frame_end_q, frame_end_d;
  logic [CNT_W-1:0]  frame_count_q, frame_count_d;
  logic [CNT_W-1:0]  drop_count_q, drop_count_d;
  logic              arm_now;
  logic              frame_decide;
  logic              stop_now;
`ifdef ACQ_FRAME_LIMIT_EN
  logic [CNT_W-1:0]  limit_q, limit_d;
  logic              rearm_block_q, rearm_block_d;
  logic              limit_done_q, limit_done_d;
`endif

  // Next-state and output decode; fifo_full is only looked at on the frame-start decision
  always_comb begin
    state_d        = state_q;
    accepted_d     = accepted_q;
    sample_valid_d = 1'b0;
    slot_idx_d     = slot_idx_q;
    frame_start_d  = 1'b0;
    frame_end_d    = 1'b0;
    frame_count_d  = frame_count_q;
    drop_count_d   = drop_count_q;
    arm_now        = 1'b0;
    frame_decide   = 1'b0;
    stop_now       = 1'b0;
`ifdef ACQ_FRAME_LIMIT_EN
    limit_d        = limit_q;
    rearm_block_d  = rearm_block_q;
    limit_done_d   = 1'b0;
`endif

    case (state_q)
      IDLE: begin
`ifdef ACQ_FRAME_LIMIT_EN
        if (!en) rearm_block_d = 1'b0;
        arm_now = en && !rearm_block_q;
        if (arm_now) limit_d = frame_limit;
`else
        arm_now = en;
`endif
        if (arm_now) begin
          state_d       = ARM;
          frame_count_d = '0;
          drop_count_d  = '0;
        end
      end
      ARM: begin
        if (!en) begin
          state_d = IDLE;
        end else if (tick && slot_first) begin
          frame_decide = 1'b1;
          state_d      = RUN;
        end
      end
      RUN: begin
        if (tick) begin
          if (slot_first) begin
            frame_decide = 1'b1;
          end else if (accepted_q) begin
            sample_valid_d = 1'b1;
            slot_idx_d     = cur_slot;
          end
          // The frame only ever closes here, so a stop never truncates a frame
          if (slot_last) begin
            if (accepted_q) begin
              frame_end_d   = 1'b1;
              frame_count_d = CNT_W'(sat_inc(SAT_W'(frame_count_q), CNT_MAX));
`ifdef ACQ_FRAME_LIMIT_EN
              if ((limit_q != '0) && (frame_count_d == limit_q)) begin
                stop_now      = 1'b1;
                limit_done_d  = 1'b1;
                rearm_block_d = 1'b1;
              end
`endif
            end
            if (!en || stop_now) state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Accept or skip the whole upcoming frame
    if (frame_decide) begin
      if (!fifo_full) begin
        accepted_d     = 1'b1;
        sample_valid_d = 1'b1;
        slot_idx_d     = '0;
        frame_start_d  = 1'b1;
      end else begin
        accepted_d   = 1'b0;
        drop_count_d = CNT_W'(sat_inc(SAT_W'(drop_count_q), CNT_MAX));
      end
    end

    running_d = (state_d == RUN);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      accepted_q     <= 1'b0;
      running_q      <= 1'b0;
      sample_valid_q <= 1'b0;
      slot_idx_q     <= '0;
      frame_start_q  <= 1'b0;
      frame_end_q    <= 1'b0;
      frame_count_q  <= '0;
      drop_count_q   <= '0;
`ifdef ACQ_FRAME_LIMIT_EN
      limit_q        <= '0;
      rearm_block_q  <= 1'b0;
      limit_done_q   <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      accepted_q     <= accepted_d;
      running_q      <= running_d;
      sample_valid_q <= sample_valid_d;
      slot_idx_q     <= slot_idx_d;
      frame_start_q  <= frame_start_d;
      frame_end_q    <= frame_end_d;
      frame_count_q  <= frame_count_d;
      drop_count_q   <= drop_count_d;
`ifdef ACQ_FRAME_LIMIT_EN
      limit_q        <= limit_d;
      rearm_block_q  <= rearm_block_d;
      limit_done_q   <= limit_done_d;
`endif
    end
  end

  assign running      = running_q;
  assign sample_valid = sample_valid_q;
  assign slot_idx     = slot_idx_q;
  assign frame_start  = frame_start_q;
  assign frame_end    = frame_end_q;
  assign frame_count  = frame_count_q;
  assign drop_count   = drop_count_q;
`ifdef ACQ_FRAME_LIMIT_EN
  assign limit_done   = limit_done_q;
`endif

endmodule

// File: doc/acq_frame_sequencer.md
Name: acq_frame_sequencer

Overview:
- Consumes the synchronized, debounced acquisition-enable level produced by the clock-crossing enable stage in the acquisition clock domain.
- Converts that level into frame-aligned start/stop of sample streaming, so acquisition always begins at slot 0 and always ends on a complete frame.
- Emits per-slot sample strobes with slot index, frame boundary pulses, a frame counter and a dropped-frame counter toward the sample packer/FIFO.

Parameters:
- SLOTS_PER_FRAME, 35, sample slots per frame (32 channels + 3 aux); must be >= 2.
- SLOT_W, 6, width of slot index; must satisfy 2^SLOT_W >= SLOTS_PER_FRAME.
- CNT_W, 32, width of frame and drop counters.

Ports:
- clk  in  1  acquisition clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  synchronized enable level, already in the clk domain.
- tick  in  1  one-cycle slot strobe from the chip sequencer; at most one per cycle.
- fifo_full  in  1  downstream FIFO cannot accept a new frame.
- running  out  1  high while frames are being streamed (RUN state).
- sample_valid  out  1  one-cycle strobe, one per slot of an accepted frame.
- slot_idx  out  SLOT_W  slot index qualified by sample_valid.
- frame_start  out  1  one-cycle pulse coincident with sample_valid at slot 0 of an accepted frame.
- frame_end  out  1  one-cycle pulse coincident with sample_valid at slot SLOTS_PER_FRAME-1.
- frame_count  out  CNT_W  accepted frames completed since the last IDLE->ARM transition.
- drop_count  out  CNT_W  frames skipped due to fifo_full since the last IDLE->ARM transition.

Behaviour:
- Reset (rst_n low, async): state IDLE, slot counter 0, all outputs 0, both counters 0.
- Slot counter: free-runs on every tick regardless of state; wraps SLOTS_PER_FRAME-1 -> 0. Its value before increment is the "current slot".
- All outputs are registered. sample_valid, frame_start and frame_end assert one cycle after the qualifying tick.
- IDLE:
  - en=1 -> ARM.
  - On that transition, clear frame_count and drop_count.
- ARM:
  - en=0 -> IDLE.
  - tick with current slot 0 -> frame-start decision (below), then RUN.
- Frame-start decision, evaluated at the slot-0 tick:
  - fifo_full=0: frame accepted; emit sample_valid, slot_idx=0, frame_start=1.
  - fifo_full=1: frame skipped; no strobes for any slot of this frame; drop_count+1 (saturating).
- RUN:
  - Each tick in an accepted frame emits sample_valid with slot_idx equal to the current slot.
  - Tick at the last slot emits frame_end and increments frame_count (saturating). In a skipped frame, the counter is not incremented.
  - At the last-slot tick: en=0 -> IDLE (running drops the following cycle); otherwise stay in RUN, and the next slot-0 tick repeats the frame-start decision.
  - en falling mid-frame never truncates the frame; it is sampled only at the last-slot tick.
- fifo_full is sampled only at slot-0 ticks; mid-frame assertion is ignored (the FIFO reserves space per frame).
- en toggling in ARM without a slot-0 tick produces no output activity.
- running=1 in RUN only; frame_count and drop_count hold their values in IDLE until the next arm.

Optional Feature:
- Macro: ACQ_FRAME_LIMIT_EN.
- With the macro defined:
  - Adds input frame_limit (CNT_W) and output limit_done (1).
  - frame_limit is sampled on the IDLE->ARM transition.
  - A nonzero limit forces RUN->IDLE at the frame_end that makes frame_count equal the limit, even if en=1; limit_done pulses for one cycle coincident with that frame_end.
  - Re-arming requires en to go low, then high again.
  - A limit of 0 means unlimited.
- Without the macro: no ports added; only en controls stopping.

Decomposition:
- Shared package acq_pkg:
  - state enum (IDLE, ARM, RUN);
  - SLOTS_PER_FRAME default constant;
  - saturating-increment function.
- One natural sub-module, acq_slot_counter: tick-driven wrap counter exposing current slot, is_first and is_last.

Test Plan:
- Reset with en=1 and ticks running -> all outputs 0 until rst_n release; after release, first sample_valid at the first slot-0 tick only, never mid-frame.
- en rises at slot 17 -> no strobes for slots 17..34; frame_start at next slot 0; exactly 35 sample_valid with slot_idx 0..34; frame_end at 34; frame_count=1.
- en falls at slot 10 of frame 3 -> slots 11..34 still emitted; IDLE after frame_end; frame_count=3; running=0 one cycle after the final strobe.
- fifo_full=1 at the slot-0 tick of frame 2 only -> no strobes for frame 2; drop_count=1; frame 3 streams normally; frame_count=2 after frame 3.
- fifo_full toggles mid-frame with en held high -> no effect; all 35 strobes emitted.
- ACQ_FRAME_LIMIT_EN, frame_limit=2, en held high -> two full frames, limit_done with the second frame_end, then IDLE; no restart until en goes 0 then 1.
